// File: rtl/div_ctrl_pkg.sv
// Shared EX-stage definitions for the multi-cycle divide unit: state encodings,
// iteration count and the R-type funct codes that select DIV/DIVU.
package div_ctrl_pkg;

  localparam int DIV_CYCLES = 32;

  localparam logic [5:0] FUNCT_DIV  = 6'b011010;
  localparam logic [5:0] FUNCT_DIVU = 6'b011011;

  typedef enum logic [1:0] {
    DIV_IDLE   = 2'd0,
    DIV_RUN    = 2'd1,
    DIV_FINISH = 2'd2
  } div_state_e;

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration on unsigned magnitudes. The quotient bit is
// shifted into the low end of the dividend register as its MSB is consumed.
module div_step
  import div_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic [DATA_WIDTH:0]   partial_rem,
  input  logic [DATA_WIDTH-1:0] dividend_shift,
  input  logic [DATA_WIDTH-1:0] divisor,
  output logic [DATA_WIDTH:0]   next_rem,
  output logic [DATA_WIDTH-1:0] next_shift,
  output logic                  q_bit
);

  logic [DATA_WIDTH+1:0] rem_shift;

  // NOTE: every always_comb output gets an unconditional assignment on each
  // path, so no latch can be inferred.
  always_comb begin
    rem_shift  = {partial_rem, dividend_shift[DATA_WIDTH-1]};
    q_bit      = (rem_shift >= {2'b00, divisor});
    next_rem   = q_bit ? (DATA_WIDTH+1)'(rem_shift - {2'b00, divisor})
                       : rem_shift[DATA_WIDTH:0];
    next_shift = {dividend_shift[DATA_WIDTH-2:0], q_bit};
  end

endmodule

// File: rtl/div_ctrl.sv
// Multi-cycle DIV/DIVU controller: latches operand magnitudes, runs one
// restoring step per cycle, applies sign fixup and stalls the pipe while busy.
module div_ctrl
  import div_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  start,
  input  logic                  signed_div,
  input  logic [DATA_WIDTH-1:0] dividend,
  input  logic [DATA_WIDTH-1:0] divisor,
  output logic                  stall_req,
  output logic                  busy,
  output logic                  done,
  output logic                  div_by_zero,
  output logic [DATA_WIDTH-1:0] quotient,
  output logic [DATA_WIDTH-1:0] remainder
);

  div_state_e state, state_next;

  logic [CNT_WIDTH-1:0]  count;
  logic [DATA_WIDTH:0]   rem_acc;
  logic [DATA_WIDTH-1:0] shift_acc;
  logic [DATA_WIDTH-1:0] divisor_abs;
  logic                  neg_quot;
  logic                  neg_rem;

  logic [DATA_WIDTH:0]   step_rem;
  logic [DATA_WIDTH-1:0] step_shift;
  logic                  step_q;

  logic                  accept;
  logic                  last_step;
  logic                  dividend_neg;
  logic                  divisor_neg;
  logic [DATA_WIDTH-1:0] dividend_mag;
  logic [DATA_WIDTH-1:0] divisor_mag;
  logic [DATA_WIDTH-1:0] quot_raw;
  logic [DATA_WIDTH-1:0] rem_raw;

  assign accept       = (state == DIV_IDLE) && start && !flush;
  assign last_step    = (state == DIV_RUN) && (count == CNT_WIDTH'(DIV_CYCLES - 1));
  assign dividend_neg = signed_div & dividend[DATA_WIDTH-1];
  assign divisor_neg  = signed_div & divisor[DATA_WIDTH-1];
  // Two's-complement negate wraps, so the most negative value stays as its own magnitude.
  assign dividend_mag = dividend_neg ? -dividend : dividend;
  assign divisor_mag  = divisor_neg  ? -divisor  : divisor;
  assign quot_raw     = {shift_acc[DATA_WIDTH-2:0], step_q};
  assign rem_raw      = step_rem[DATA_WIDTH-1:0];

  div_step #(.DATA_WIDTH(DATA_WIDTH)) u_step (
    .partial_rem    (rem_acc),
    .dividend_shift (shift_acc),
    .divisor        (divisor_abs),
    .next_rem       (step_rem),
    .next_shift     (step_shift),
    .q_bit          (step_q)
  );

  // NOTE: sequential state is written with non-blocking assignments so every
  // register samples pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) state <= DIV_IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    if (flush) begin
      state_next = DIV_IDLE;
    end else begin
      unique case (state)
        DIV_IDLE:   if (start) state_next = (divisor == '0) ? DIV_FINISH : DIV_RUN;
        DIV_RUN:    if (last_step) state_next = DIV_FINISH;
        DIV_FINISH: state_next = DIV_IDLE;
        default:    state_next = DIV_IDLE;
      endcase
    end
  end

  always_comb begin
    busy      = (state != DIV_IDLE);
    done      = (state == DIV_FINISH);
    stall_req = accept || (state == DIV_RUN);
  end

  // Results change only on entry to FINISH; a flush leaves them untouched.
  always_ff @(posedge clk) begin
    if (rst) begin
      count       <= '0;
      rem_acc     <= '0;
      shift_acc   <= '0;
      divisor_abs <= '0;
      neg_quot    <= 1'b0;
      neg_rem     <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else if (!flush) begin
      if (accept) begin
        count       <= '0;
        rem_acc     <= '0;
        shift_acc   <= dividend_mag;
        divisor_abs <= divisor_mag;
        neg_quot    <= dividend_neg ^ divisor_neg;
        neg_rem     <= dividend_neg;
        if (divisor == '0) begin
          quotient    <= '1;
          remainder   <= dividend;
          div_by_zero <= 1'b1;
        end
      end else if (state == DIV_RUN) begin
        count     <= count + CNT_WIDTH'(1);
        rem_acc   <= step_rem;
        shift_acc <= step_shift;
        if (last_step) begin
          quotient    <= neg_quot ? -quot_raw : quot_raw;
          remainder   <= neg_rem  ? -rem_raw  : rem_raw;
          div_by_zero <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_div_ctrl.sv
// Self-checking bench for div_ctrl: directed corner cases plus random divides
// compared against a plain-arithmetic reference model.
module tb_div_ctrl;

  logic        clk = 1'b0;
  logic        rst, flush, start, signed_div;
  logic [31:0] dividend, divisor;
  logic        stall_req, busy, done, div_by_zero;
  logic [31:0] quotient, remainder;

  int checks = 0;
  int errors = 0;

  logic [31:0] last_q, last_r;
  logic        last_z;

  div_ctrl #(.DATA_WIDTH(32), .CNT_WIDTH(6)) dut (
    .clk         (clk),
    .rst         (rst),
    .flush       (flush),
    .start       (start),
    .signed_div  (signed_div),
    .dividend    (dividend),
    .divisor     (divisor),
    .stall_req   (stall_req),
    .busy        (busy),
    .done        (done),
    .div_by_zero (div_by_zero),
    .quotient    (quotient),
    .remainder   (remainder)
  );

  always #5 clk = ~clk;

  // Reference: truncating division in 64-bit arithmetic, results cut to 32 bits.
  function automatic void model(input logic [31:0] a, input logic [31:0] b, input logic sgn,
                                output logic [31:0] q, output logic [31:0] r, output logic z);
    longint sa, sb, lq, lr;
    if (b == 32'd0) begin
      q = 32'hFFFF_FFFF; r = a; z = 1'b1;
    end else if (!sgn) begin
      q = a / b; r = a % b; z = 1'b0;
    end else begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      lq = sa / sb;
      lr = sa % sb;
      q = lq[31:0]; r = lr[31:0]; z = 1'b0;
    end
  endfunction

  // Runs one divide; poke_at > 0 re-pulses start (other operands) that many cycles after accept.
  task automatic run_div(input logic [31:0] a, input logic [31:0] b, input logic sgn,
                         input int poke_at, input string tag);
    logic [31:0] eq, er;
    logic        ez;
    int          k, want_k;
    bit          stall_ok;
    model(a, b, sgn, eq, er, ez);
    want_k = (b == 32'd0) ? 1 : 33;
    @(negedge clk);
    dividend = a; divisor = b; signed_div = sgn; start = 1'b1;
    #1;
    checks++;
    if (stall_req !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL %s accept: stall_req=%b busy=%b, need 1 0", tag, stall_req, busy);
    end
    @(posedge clk);
    #1;
    start = 1'b0; dividend = $urandom; divisor = $urandom; signed_div = ~sgn;
    k = 0; stall_ok = 1'b1;
    while (k < 60) begin
      @(negedge clk);
      k++;
      if (done === 1'b1) break;
      if (stall_req !== 1'b1 || busy !== 1'b1) stall_ok = 1'b0;
      start = (k == poke_at);
    end
    start = 1'b0;
    checks++;
    if (!stall_ok) begin
      errors++;
      $display("FAIL %s stall: stall_req/busy dropped while dividing, need 1", tag);
    end
    checks++;
    if (k != want_k) begin
      errors++;
      $display("FAIL %s latency: done after %0d cycles, need %0d", tag, k, want_k);
    end
    checks++;
    if (quotient !== eq || remainder !== er || div_by_zero !== ez) begin
      errors++;
      $display("FAIL %s result: q=%h r=%h z=%b, need q=%h r=%h z=%b",
               tag, quotient, remainder, div_by_zero, eq, er, ez);
    end
    checks++;
    if (stall_req !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL %s finish: stall_req=%b busy=%b, need 0 1", tag, stall_req, busy);
    end
    @(posedge clk);
    #1;
    checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL %s after: done=%b busy=%b, need 0 0", tag, done, busy);
    end
    last_q = eq; last_r = er; last_z = ez;
  endtask

  task automatic test_reset();
    rst = 1'b1; flush = 1'b0; start = 1'b0; signed_div = 1'b0;
    dividend = '0; divisor = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || stall_req !== 1'b0 || div_by_zero !== 1'b0 ||
        quotient !== 32'd0 || remainder !== 32'd0) begin
      errors++;
      $display("FAIL reset: busy=%b done=%b stall=%b z=%b q=%h r=%h, need all zero",
               busy, done, stall_req, div_by_zero, quotient, remainder);
    end
  endtask

  task automatic test_directed();
    run_div(32'd100, 32'd7, 1'b0, 0, "udiv_100_7");
    run_div(32'hFFFF_FFF9, 32'd2, 1'b1, 0, "sdiv_m7_2");
    run_div(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 0, "sdiv_min_m1");
    run_div(32'h0000_1234, 32'd0, 1'b0, 0, "div_zero");
    run_div(32'hFFFF_FFFF, 32'd1, 1'b0, 0, "udiv_max_1");
    run_div(32'd7, 32'hFFFF_FFF9, 1'b1, 0, "sdiv_7_m7");
  endtask

  task automatic test_flush();
    int k;
    bit quiet;
    @(negedge clk);
    dividend = 32'd100000; divisor = 32'd7; signed_div = 1'b0; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (10) @(negedge clk);
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    quiet = 1'b1;
    for (k = 0; k < 40; k++) begin
      @(negedge clk);
      if (done !== 1'b0 || busy !== 1'b0 || stall_req !== 1'b0) quiet = 1'b0;
    end
    checks++;
    if (!quiet) begin
      errors++;
      $display("FAIL flush_abort: done/busy/stall seen after flush, need 0");
    end
    checks++;
    if (quotient !== last_q || remainder !== last_r || div_by_zero !== last_z) begin
      errors++;
      $display("FAIL flush_hold: q=%h r=%h z=%b, need q=%h r=%h z=%b",
               quotient, remainder, div_by_zero, last_q, last_r, last_z);
    end
    run_div(32'd9, 32'd3, 1'b0, 0, "after_flush_9_3");
  endtask

  task automatic test_ignored_start();
    @(negedge clk);
    dividend = 32'd55; divisor = 32'd0; signed_div = 1'b0; start = 1'b1; flush = 1'b1;
    #1;
    checks++;
    if (stall_req !== 1'b0) begin
      errors++;
      $display("FAIL start_with_flush stall: stall_req=%b, need 0", stall_req);
    end
    @(posedge clk);
    #1;
    start = 1'b0; flush = 1'b0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || quotient !== last_q) begin
      errors++;
      $display("FAIL start_with_flush: busy=%b done=%b q=%h, need 0 0 %h",
               busy, done, quotient, last_q);
    end
    run_div(32'd1000, 32'd33, 1'b0, 5, "restart_in_div");
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    dividend = 32'd500; divisor = 32'd9; signed_div = 1'b0; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (6) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || stall_req !== 1'b0 || div_by_zero !== 1'b0 ||
        quotient !== 32'd0 || remainder !== 32'd0) begin
      errors++;
      $display("FAIL reset_mid: busy=%b done=%b stall=%b z=%b q=%h r=%h, need all zero",
               busy, done, stall_req, div_by_zero, quotient, remainder);
    end
    run_div(32'd500, 32'd9, 1'b0, 0, "after_reset_500_9");
  endtask

  task automatic test_random();
    logic [31:0] a, b;
    logic        sgn;
    for (int i = 0; i < 24; i++) begin
      a   = $urandom;
      sgn = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 3))
        0:       b = 32'($urandom_range(1, 15));
        1:       b = (i % 6 == 0) ? 32'd0 : $urandom;
        2:       b = 32'hFFFF_FFFF - 32'($urandom_range(0, 3));
        default: b = $urandom >> $urandom_range(0, 31);
      endcase
      run_div(a, b, sgn, 0, "random");
    end
  endtask

  initial begin
    last_q = '0; last_r = '0; last_z = 1'b0;
    test_reset();
    test_directed();
    test_flush();
    test_ignored_start();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
